// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SPI-mode SD card device model (card end of the link).
// Oversamples SCLK/CS_n/MOSI in the CLK domain, decodes 48-bit commands,
// answers CMD0/CMD55/ACMD41/CMD17 with R1 and streams read blocks from a
// byte-read port.
// Build option: define SDRESP_CRC_EN to check the CMD0 CRC7 and to send the
// real CRC16-CCITT after each data block (otherwise CRC7 is ignored and the
// CRC bytes are 0xFF,0xFF).
`timescale 1ns/1ps
module sd_spi_responder #(
   parameter int INIT_POLLS  = 2,
   parameter int NCR_BYTES   = 1,
   parameter int NAC_BYTES   = 2,
   parameter int BLOCK_BYTES = 512
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        sd_sclk_i,
   input  logic        sd_cs_n_i,
   input  logic        sd_mosi_i,
   output logic        sd_miso_o,
   output logic        rd_req_o,
   output logic [31:0] rd_addr_o,
   input  logic [7:0]  rd_data_i,
   input  logic        rd_ack_i,
   output logic        cmd_valid_o,
   output logic [5:0]  cmd_index_o,
   output logic [31:0] cmd_arg_o,
   output logic        ready_o
);

   typedef enum logic [2:0] {
      ST_HUNT, ST_CMD_RX, ST_GAP, ST_R1, ST_DGAP, ST_TOKEN, ST_DATA, ST_CRC
   } state_t;

   localparam logic [7:0]  POLLS_L  = 8'(INIT_POLLS);
   localparam logic [15:0] NCR_LAST = 16'(NCR_BYTES - 1);
   localparam logic [15:0] NAC_LAST = 16'(NAC_BYTES - 1);
   localparam logic [15:0] BLK_LAST = 16'(BLOCK_BYTES - 1);
   // Zero-length filler phases are skipped entirely.
   localparam state_t ST_AFTER_CMD = (NCR_BYTES == 0) ? ST_R1 : ST_GAP;
   localparam state_t ST_AFTER_R1  = (NAC_BYTES == 0) ? ST_TOKEN : ST_DGAP;

`ifdef SDRESP_CRC_EN
   function automatic logic [6:0] crc7_40(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int k = 39; k >= 0; k--) begin
         fb = d[k] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] b);
      logic [15:0] c;
      logic        fb;
      c = c_in;
      for (int k = 7; k >= 0; k--) begin
         fb = b[k] ^ c[15];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction
`endif

   logic        sclk_meta_q, sclk_sync_q, sclk_prev_q;
   logic        cs_meta_q, cs_sync_q, mosi_meta_q, mosi_sync_q;
   state_t      state_q, state_d;
   logic [2:0]  bitcnt_q, bitcnt_d;
   logic [5:0]  cmdcnt_q, cmdcnt_d;
   logic [15:0] bytecnt_q, bytecnt_d;
   logic        load_pend_q, load_pend_d;
   logic        miso_q, miso_d;
   logic [7:0]  r1_q, r1_d;
   logic        blk_q, blk_d;
   logic        ready_q, ready_d, ready_pend_q, ready_pend_d;
   logic [7:0]  poll_q, poll_d;
   logic        app_q, app_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic [5:0]  cmd_index_q, cmd_index_d;
   logic [31:0] cmd_arg_q, cmd_arg_d;
   logic        rd_req_q, rd_req_d;
   logic [31:0] rd_addr_q, rd_addr_d;
   logic        dvalid_q, dvalid_d;
   logic [45:0] sh_q, sh_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic [7:0]  dbuf_q, dbuf_d;
`ifdef SDRESP_CRC_EN
   logic [15:0] crc_q, crc_d;
`endif

   logic        rise, fall;
   logic [46:0] nxt;
   logic [7:0]  ld_byte;
   logic        idle;

   assign rise = sclk_sync_q & ~sclk_prev_q;
   assign fall = ~sclk_sync_q & sclk_prev_q;

   // Two-flop synchronisers on the SPI pins plus the SCLK edge register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sclk_meta_q <= 1'b0; sclk_sync_q <= 1'b0; sclk_prev_q <= 1'b0;
         cs_meta_q   <= 1'b1; cs_sync_q   <= 1'b1;
         mosi_meta_q <= 1'b1; mosi_sync_q <= 1'b1;
      end else begin
         sclk_meta_q <= sd_sclk_i; sclk_sync_q <= sclk_meta_q; sclk_prev_q <= sclk_sync_q;
         cs_meta_q   <= sd_cs_n_i; cs_sync_q   <= cs_meta_q;
         mosi_meta_q <= sd_mosi_i; mosi_sync_q <= mosi_meta_q;
      end
   end

   // Protocol state register and control outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_HUNT;
         bitcnt_q     <= '0;
         cmdcnt_q     <= '0;
         bytecnt_q    <= '0;
         load_pend_q  <= 1'b0;
         miso_q       <= 1'b1;
         r1_q         <= 8'hFF;
         blk_q        <= 1'b0;
         ready_q      <= 1'b0;
         ready_pend_q <= 1'b0;
         poll_q       <= '0;
         app_q        <= 1'b0;
         cmd_valid_q  <= 1'b0;
         cmd_index_q  <= '0;
         cmd_arg_q    <= '0;
         rd_req_q     <= 1'b0;
         rd_addr_q    <= '0;
         dvalid_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         bitcnt_q     <= bitcnt_d;
         cmdcnt_q     <= cmdcnt_d;
         bytecnt_q    <= bytecnt_d;
         load_pend_q  <= load_pend_d;
         miso_q       <= miso_d;
         r1_q         <= r1_d;
         blk_q        <= blk_d;
         ready_q      <= ready_d;
         ready_pend_q <= ready_pend_d;
         poll_q       <= poll_d;
         app_q        <= app_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_index_q  <= cmd_index_d;
         cmd_arg_q    <= cmd_arg_d;
         rd_req_q     <= rd_req_d;
         rd_addr_q    <= rd_addr_d;
         dvalid_q     <= dvalid_d;
      end
   end

   // Shift registers and the read-data buffer carry no reset.
   always_ff @(posedge clk_i) begin
      sh_q    <= sh_d;
      tx_sh_q <= tx_sh_d;
      dbuf_q  <= dbuf_d;
`ifdef SDRESP_CRC_EN
      crc_q   <= crc_d;
`endif
   end

   // Next-state: command capture, R1 decode, byte sequencing and read requests.
   always_comb begin
      state_d      = state_q;
      bitcnt_d     = bitcnt_q;
      cmdcnt_d     = cmdcnt_q;
      bytecnt_d    = bytecnt_q;
      load_pend_d  = load_pend_q;
      miso_d       = miso_q;
      r1_d         = r1_q;
      blk_d        = blk_q;
      ready_d      = ready_q;
      ready_pend_d = ready_pend_q;
      poll_d       = poll_q;
      app_d        = app_q;
      cmd_valid_d  = 1'b0;
      cmd_index_d  = cmd_index_q;
      cmd_arg_d    = cmd_arg_q;
      rd_req_d     = rd_req_q;
      rd_addr_d    = rd_addr_q;
      dvalid_d     = dvalid_q;
      sh_d         = sh_q;
      tx_sh_d      = tx_sh_q;
      dbuf_d       = dbuf_q;
`ifdef SDRESP_CRC_EN
      crc_d        = crc_q;
`endif
      nxt     = {sh_q, mosi_sync_q};
      ld_byte = 8'hFF;
      idle    = ~ready_q;

      // Acknowledged read data is parked until its byte slot comes up.
      if (rd_req_q && rd_ack_i) begin
         dbuf_d   = rd_data_i;
         dvalid_d = 1'b1;
         rd_req_d = 1'b0;
      end

      if (cs_sync_q) begin
         // Deselect aborts any frame; READY and the poll count survive.
         state_d      = ST_HUNT;
         miso_d       = 1'b1;
         rd_req_d     = 1'b0;
         dvalid_d     = 1'b0;
         ready_pend_d = 1'b0;
         bitcnt_d     = '0;
         load_pend_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_HUNT: begin
               if (fall) miso_d = 1'b1;
               if (rise && !mosi_sync_q) begin
                  state_d  = ST_CMD_RX;
                  sh_d     = '0;
                  cmdcnt_d = '0;
               end
            end
            ST_CMD_RX: begin
               if (fall) miso_d = 1'b1;
               if (rise) begin
                  sh_d     = nxt[45:0];
                  cmdcnt_d = cmdcnt_q + 6'd1;
                  if (cmdcnt_q == 6'd46) begin
                     // nxt now holds frame bits 46..0 (bit 47 was the start bit).
                     state_d     = ST_AFTER_CMD;
                     bytecnt_d   = '0;
                     bitcnt_d    = '0;
                     load_pend_d = 1'b1;
                     blk_d       = 1'b0;
                     if (!nxt[46] || !nxt[0]) begin
                        r1_d = 8'h05;
                     end else begin
                        cmd_valid_d = 1'b1;
                        cmd_index_d = nxt[45:40];
                        cmd_arg_d   = nxt[39:8];
                        app_d       = 1'b0;
                        unique case (nxt[45:40])
                           6'd0: begin
`ifdef SDRESP_CRC_EN
                              if (crc7_40({1'b0, nxt[46:8]}) != nxt[7:1]) begin
                                 r1_d  = 8'h09;
                                 app_d = app_q;
                              end else begin
                                 r1_d         = 8'h01;
                                 ready_d      = 1'b0;
                                 ready_pend_d = 1'b0;
                                 poll_d       = '0;
                              end
`else
                              r1_d         = 8'h01;
                              ready_d      = 1'b0;
                              ready_pend_d = 1'b0;
                              poll_d       = '0;
`endif
                           end
                           6'd55: begin
                              r1_d  = {7'b0, idle};
                              app_d = 1'b1;
                           end
                           6'd41: begin
                              if (!app_q) begin
                                 r1_d = {7'b0, idle} | 8'h04;
                              end else if (poll_q < POLLS_L) begin
                                 r1_d   = 8'h01;
                                 poll_d = poll_q + 8'd1;
                              end else begin
                                 // READY asserts once this 0x00 has been shifted out.
                                 r1_d         = 8'h00;
                                 ready_pend_d = 1'b1;
                              end
                           end
                           6'd17: begin
                              r1_d  = ready_q ? 8'h00 : 8'h05;
                              blk_d = ready_q;
                           end
                           default: r1_d = {7'b0, idle} | 8'h04;
                        endcase
                     end
                  end
               end
            end
            default: begin
               // Response phases: MOSI is ignored, MISO changes on SCLK falls.
               if (fall) begin
                  if (load_pend_q) begin
                     load_pend_d = 1'b0;
                     unique case (state_q)
                        ST_R1: begin
                           ld_byte = r1_q;
                           if (blk_q) begin
                              rd_req_d  = 1'b1;
                              rd_addr_d = cmd_arg_q;
                              dvalid_d  = 1'b0;
`ifdef SDRESP_CRC_EN
                              crc_d     = '0;
`endif
                           end
                        end
                        ST_TOKEN: ld_byte = 8'hFE;
                        ST_DATA: begin
                           // A byte whose ack never came goes out as 0xFF.
                           if (dvalid_q)                  ld_byte = dbuf_q;
                           else if (rd_req_q && rd_ack_i) ld_byte = rd_data_i;
                           else                           ld_byte = 8'hFF;
                           dvalid_d = 1'b0;
                           rd_req_d = 1'b0;
                           if (bytecnt_q != BLK_LAST) begin
                              rd_req_d  = 1'b1;
                              rd_addr_d = rd_addr_q + 32'd1;
                           end
`ifdef SDRESP_CRC_EN
                           crc_d = crc16_byte(crc_q, ld_byte);
`endif
                        end
                        ST_CRC: begin
`ifdef SDRESP_CRC_EN
                           ld_byte = (bytecnt_q == 16'd0) ? crc_q[15:8] : crc_q[7:0];
`else
                           ld_byte = 8'hFF;
`endif
                        end
                        default: ld_byte = 8'hFF;
                     endcase
                     miso_d  = ld_byte[7];
                     tx_sh_d = {ld_byte[6:0], 1'b1};
                  end else begin
                     miso_d  = tx_sh_q[7];
                     tx_sh_d = {tx_sh_q[6:0], 1'b1};
                  end
               end
               if (rise) begin
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) begin
                     load_pend_d = 1'b1;
                     unique case (state_q)
                        ST_GAP: begin
                           if (bytecnt_q == NCR_LAST) begin
                              state_d   = ST_R1;
                              bytecnt_d = '0;
                           end else bytecnt_d = bytecnt_q + 16'd1;
                        end
                        ST_R1: begin
                           if (ready_pend_q) begin
                              ready_d      = 1'b1;
                              ready_pend_d = 1'b0;
                           end
                           bytecnt_d = '0;
                           if (blk_q) state_d = ST_AFTER_R1;
                           else begin
                              state_d     = ST_HUNT;
                              load_pend_d = 1'b0;
                           end
                        end
                        ST_DGAP: begin
                           if (bytecnt_q == NAC_LAST) begin
                              state_d   = ST_TOKEN;
                              bytecnt_d = '0;
                           end else bytecnt_d = bytecnt_q + 16'd1;
                        end
                        ST_TOKEN: begin
                           state_d   = ST_DATA;
                           bytecnt_d = '0;
                        end
                        ST_DATA: begin
                           if (bytecnt_q == BLK_LAST) begin
                              state_d   = ST_CRC;
                              bytecnt_d = '0;
                           end else bytecnt_d = bytecnt_q + 16'd1;
                        end
                        ST_CRC: begin
                           if (bytecnt_q == 16'd1) begin
                              state_d     = ST_HUNT;
                              load_pend_d = 1'b0;
                           end else bytecnt_d = bytecnt_q + 16'd1;
                        end
                        default: load_pend_d = 1'b0;
                     endcase
                  end
               end
            end
         endcase
      end
   end

   assign sd_miso_o   = miso_q;
   assign rd_req_o    = rd_req_q;
   assign rd_addr_o   = rd_addr_q;
   assign cmd_valid_o = cmd_valid_q;
   assign cmd_index_o = cmd_index_q;
   assign cmd_arg_o   = cmd_arg_q;
   assign ready_o     = ready_q;

endmodule
